serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 112 +++++++++++
 tb/tb_serial_adder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full-adder cell used by the serial adder datapath (purely combinational).
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: computes a_in + b_in + cin one bit per clock, LSB first.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the registered two's-complement
// overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    // Counter wide enough to hold WIDTH itself, so it never wraps before the last bit.
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_sr_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             fa_s;
    logic             fa_co;

    fa_cell u_fa_cell (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
    assign s_sr_next = (s_sr >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last_bit  = (cnt == CW'(WIDTH - 1));

    // FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        s_sr  <= '0;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately ignored here.
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= s_sr_next;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= s_sr_next;
                        cout  <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry holds the carry into the MSB during the last bit.
                        ovf   <= carry ^ fa_co;
`endif
                        state <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8, 3 and 1.
module tb_serial_adder;

    typedef struct {
        int sum;
        int cout;
        int ovf;
        int lo;
        int hi;
        int done_at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start3 = 1'b0, cin3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0;
    logic       busy3, done3, cout3;
    logic [2:0] sum3;

    logic       start1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf8, ovf3, ovf1;
`endif

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .a_in(a3), .b_in(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf3)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    exp_t q8[$], q3[$], q1[$];
    exp_t e8, e3, e1;
    int hs8 = 0, hc8 = 0, ho8 = 0;
    int hs3 = 0, hc3 = 0, ho3 = 0;
    int hs1 = 0, hc1 = 0, ho1 = 0;

    // Reference: plain integer arithmetic on the operands. c is the cycle count when
    // start is driven; it is sampled on the next edge, so busy spans the following w
    // cycles and done comes right after.
    function automatic exp_t model(int w, int a, int b, int ci, int c);
        exp_t   e;
        longint t, sa, sb, st, half;
        half   = longint'(1) << (w - 1);
        t      = longint'(a) + longint'(b) + longint'(ci);
        e.sum  = int'(t % (2 * half));
        e.cout = int'(t / (2 * half));
        sa     = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
        sb     = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
        st     = sa + sb + longint'(ci);
        e.ovf  = (st >= half || st < -half) ? 1 : 0;
        e.lo      = c + 1;
        e.hi      = c + w;
        e.done_at = c + w + 1;
        return e;
    endfunction

    function automatic int busy_exp(exp_t q[$], int c);
        foreach (q[i]) if (c >= q[i].lo && c <= q[i].hi) return 1;
        return 0;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(int a, int b, int ci);
        start8 = 1'b1;
        a8     = 8'(a);
        b8     = 8'(b);
        cin8   = ci[0];
        q8.push_back(model(8, a, b, ci, cyc));
    endtask

    task automatic issue3(int a, int b, int ci);
        start3 = 1'b1;
        a3     = 3'(a);
        b3     = 3'(b);
        cin3   = ci[0];
        q3.push_back(model(3, a, b, ci, cyc));
    endtask

    task automatic issue1(int a, int b, int ci);
        start1 = 1'b1;
        a1     = 1'(a);
        b1     = 1'(b);
        cin1   = ci[0];
        q1.push_back(model(1, a, b, ci, cyc));
    endtask

    task automatic wait_idle(int which);
        int n;
        for (n = 0; n < 60; n++) begin
            if (which == 8 && q8.size() == 0) break;
            if (which == 3 && q3.size() == 0) break;
            if (which == 1 && q1.size() == 0) break;
            tick();
        end
        check("idle_timeout", (n < 60) ? 0 : 1, 0);
    endtask

    task automatic op8(int a, int b, int ci);
        issue8(a, b, ci);
        tick();
        start8 = 1'b0;
        wait_idle(8);
    endtask

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy8", int'(busy8), busy_exp(q8, cyc));
            if (done8) begin
                if (q8.size() == 0) begin
                    check("spurious_done8", int'(done8), 0);
                end else begin
                    e8 = q8.pop_front();
                    check("done_cycle8", cyc, e8.done_at);
                    hs8 = e8.sum;
                    hc8 = e8.cout;
                    ho8 = e8.ovf;
                end
            end else if (q8.size() != 0 && cyc >= q8[0].done_at) begin
                check("missing_done8", int'(done8), 1);
                void'(q8.pop_front());
            end
            check("sum8", int'(sum8), hs8);
            check("cout8", int'(cout8), hc8);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf8", int'(ovf8), ho8);
`endif
        end
    end

    // Monitor for the 3-bit and 1-bit instances.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy3", int'(busy3), busy_exp(q3, cyc));
            if (done3) begin
                if (q3.size() == 0) begin
                    check("spurious_done3", int'(done3), 0);
                end else begin
                    e3 = q3.pop_front();
                    check("done_cycle3", cyc, e3.done_at);
                    hs3 = e3.sum;
                    hc3 = e3.cout;
                    ho3 = e3.ovf;
                end
            end else if (q3.size() != 0 && cyc >= q3[0].done_at) begin
                check("missing_done3", int'(done3), 1);
                void'(q3.pop_front());
            end
            check("sum3", int'(sum3), hs3);
            check("cout3", int'(cout3), hc3);

            check("busy1", int'(busy1), busy_exp(q1, cyc));
            if (done1) begin
                if (q1.size() == 0) begin
                    check("spurious_done1", int'(done1), 0);
                end else begin
                    e1 = q1.pop_front();
                    check("done_cycle1", cyc, e1.done_at);
                    hs1 = e1.sum;
                    hc1 = e1.cout;
                    ho1 = e1.ovf;
                end
            end else if (q1.size() != 0 && cyc >= q1[0].done_at) begin
                check("missing_done1", int'(done1), 1);
                void'(q1.pop_front());
            end
            check("sum1", int'(sum1), hs1);
            check("cout1", int'(cout1), hc1);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf3", int'(ovf3), ho3);
            check("ovf1", int'(ovf1), ho1);
`endif
        end
    end

    int dn;

    initial begin
        // Reset with start asserted: it must be ignored.
        start8 = 1'b1;
        a8     = 8'hAA;
        b8     = 8'h55;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy", int'(busy8), 0);
        check("reset_done", int'(done8), 0);
        check("reset_sum", int'(sum8), 0);
        check("reset_cout", int'(cout8), 0);

        // First edge after reset accepts start.
        op8(8'h00, 8'h00, 0);
        op8(8'hFF, 8'h01, 0);
        op8(8'h5A, 8'hA5, 1);
        op8(8'h7F, 8'h01, 0);
        op8(8'h80, 8'h80, 0);

        // Start re-pulsed in cycle 3 with different operands is ignored.
        issue8(8'h12, 8'h34, 0);
        tick();
        start8 = 1'b0;
        repeat (2) tick();
        start8 = 1'b1;
        a8     = 8'hFF;
        tick();
        start8 = 1'b0;
        wait_idle(8);

        // Reset in cycle 4 of RUN aborts the operation.
        issue8(8'h21, 8'h43, 1);
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        q8.delete();
        hs8 = 0;
        hc8 = 0;
        ho8 = 0;
        rst = 1'b0;
        check("abort_busy", int'(busy8), 0);
        check("abort_sum", int'(sum8), 0);
        repeat (12) tick();
        op8(8'h03, 8'h04, 0);

        // Back-to-back: start held high through RUN and DONE.
        issue8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        dn = q8[$].done_at;
        tick();
        while (cyc < dn) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            tick();
        end
        issue8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        tick();
        start8 = 1'b0;
        wait_idle(8);

        // Randomized traffic with stray start pulses during RUN.
        issue8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        for (int n = 0; n < 25; n++) begin
            dn = q8[$].done_at;
            tick();
            while (cyc < dn) begin
                start8 = 1'($urandom_range(0, 1));
                a8     = 8'($urandom);
                b8     = 8'($urandom);
                cin8   = 1'($urandom);
                tick();
            end
            if ($urandom_range(0, 1) == 0) begin
                start8 = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            issue8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1));
        end
        tick();
        start8 = 1'b0;
        wait_idle(8);

        // Exhaustive WIDTH=3, chained through DONE.
        issue3(0, 0, 0);
        for (int i = 1; i < 128; i++) begin
            while (cyc < q3[$].done_at) tick();
            issue3(i % 8, (i / 8) % 8, i / 64);
        end
        tick();
        start3 = 1'b0;
        wait_idle(3);

        // WIDTH=1: one RUN cycle per operation.
        issue1(0, 0, 0);
        for (int i = 1; i < 8; i++) begin
            while (cyc < q1[$].done_at) tick();
            issue1(i % 2, (i / 2) % 2, i / 4);
        end
        tick();
        start1 = 1'b0;
        wait_idle(1);

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
